// File: rtl/vga_pkg.sv
// vga_pkg: 800x600@72Hz raster timing constants shared by the timing generator
// and every raster consumer (score board, snake renderer, pixel mixer).
// No ports; constants only.
package vga_pkg;

  localparam int VGA_CNT_W     = 12;

  localparam int VGA_CLK_DIV   = 2;     // 100 MHz board clock / 2 = 50 MHz pixels

  localparam int VGA_H_VISIBLE = 800;
  localparam int VGA_H_FP      = 56;
  localparam int VGA_H_SYNC    = 120;
  localparam int VGA_H_BP      = 64;

  localparam int VGA_V_VISIBLE = 600;
  localparam int VGA_V_FP      = 37;
  localparam int VGA_V_SYNC    = 6;
  localparam int VGA_V_BP      = 23;

  localparam bit VGA_HS_POL    = 1'b1;
  localparam bit VGA_VS_POL    = 1'b1;

  localparam int VGA_H_TOTAL = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;  // 1040
  localparam int VGA_V_TOTAL = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;  // 666

endpackage

// File: rtl/sync_window.sv
// sync_window: counter-range comparator used to decode sync pulses.
// Drives POL while cnt lies in [LO, HI] (inclusive, unsigned), ~POL otherwise.
// Ports:
//   cnt   in  W  raster counter being decoded
//   level out 1  sync level for this counter value (combinational)
module sync_window
  import vga_pkg::*;
#(
  parameter int W   = VGA_CNT_W,
  parameter int LO  = 1,
  parameter int HI  = 1,
  parameter bit POL = 1'b1
) (
  input  logic [W-1:0] cnt,
  output logic         level
);

  localparam logic [W-1:0] LO_V = W'(LO);
  localparam logic [W-1:0] HI_V = W'(HI);

  logic in_win;

  assign in_win = (cnt >= LO_V) && (cnt <= HI_V);
  assign level  = in_win ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster timing generator (800x600@72Hz by default).
// A clock divider produces a one-clk pixel strobe; horizontal/vertical counters
// advance on that strobe and are exported directly as the current coordinate.
// video_on/hsync/vsync are decoded from the pre-advance counters and registered,
// so they trail x_p/y_p by one pixel to line up with registered colour downstream.
// Ports:
//   clk        in   1   board clock (100 MHz)
//   reset      in   1   synchronous, active-high
//   pix_en     out  1   one-clk strobe per pixel period
//   x_p        out  12  horizontal counter, 0..H_TOTAL-1
//   y_p        out  12  vertical counter, 0..V_TOTAL-1
//   video_on   out  1   visible-area flag, one pixel late
//   hsync      out  1   horizontal sync, one pixel late
//   vsync      out  1   vertical sync, one pixel late
//   line_tick  out  1   one-clk pulse after each line wrap
//   frame_tick out  1   one-clk pulse after each frame wrap
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter int H_VISIBLE = VGA_H_VISIBLE,
  parameter int H_FP      = VGA_H_FP,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BP      = VGA_H_BP,
  parameter int V_VISIBLE = VGA_V_VISIBLE,
  parameter int V_FP      = VGA_V_FP,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BP      = VGA_V_BP,
  parameter bit HS_POL    = VGA_HS_POL,
  parameter bit VS_POL    = VGA_VS_POL
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 pix_en,
  output logic [VGA_CNT_W-1:0] x_p,
  output logic [VGA_CNT_W-1:0] y_p,
  output logic                 video_on,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 line_tick,
  output logic                 frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [VGA_CNT_W-1:0] H_LAST   = VGA_CNT_W'(H_TOTAL - 1);
  localparam logic [VGA_CNT_W-1:0] V_LAST   = VGA_CNT_W'(V_TOTAL - 1);
  localparam logic [VGA_CNT_W-1:0] H_VIS_V  = VGA_CNT_W'(H_VISIBLE);
  localparam logic [VGA_CNT_W-1:0] V_VIS_V  = VGA_CNT_W'(V_VISIBLE);

  logic [DIV_W-1:0]     div;
  logic [VGA_CNT_W-1:0] h_cnt;
  logic [VGA_CNT_W-1:0] v_cnt;
  logic                 h_wrap;
  logic                 v_wrap;
  logic                 vo_src;
  logic                 hs_src;
  logic                 vs_src;

  // Gated by reset so that with CLK_DIV = 1 no strobe leaks out while held in reset.
  assign pix_en = (div == DIV_LAST) && !reset;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);
  assign vo_src = (h_cnt < H_VIS_V) && (v_cnt < V_VIS_V);

  assign x_p = h_cnt;
  assign y_p = v_cnt;

  sync_window #(
    .W   (VGA_CNT_W),
    .LO  (H_VISIBLE + H_FP),
    .HI  (H_VISIBLE + H_FP + H_SYNC - 1),
    .POL (HS_POL)
  ) u_hsync_win (
    .cnt   (h_cnt),
    .level (hs_src)
  );

  sync_window #(
    .W   (VGA_CNT_W),
    .LO  (V_VISIBLE + V_FP),
    .HI  (V_VISIBLE + V_FP + V_SYNC - 1),
    .POL (VS_POL)
  ) u_vsync_win (
    .cnt   (v_cnt),
    .level (vs_src)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      video_on   <= 1'b0;
      hsync      <= ~HS_POL;
      vsync      <= ~VS_POL;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      line_tick  <= pix_en && h_wrap;
      frame_tick <= pix_en && h_wrap && v_wrap;
      if (pix_en) begin
        // Decode from the counters before they advance: outputs trail by one pixel.
        video_on <= vo_src;
        hsync    <= hs_src;
        vsync    <= vs_src;
        if (h_wrap) begin
          h_cnt <= '0;
          v_cnt <= v_wrap ? '0 : v_cnt + VGA_CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + VGA_CNT_W'(1);
        end
      end
    end
  end

endmodule
